// File: rtl/agc_mem_scheduler.sv
// Scheduler in front of the single-port AGC memory: arbitrates counter RMW,
// CPU and downlink accesses and drives the memory bank/address/data/WE lines.
module agc_mem_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctr_req,
    input  logic [9:0]  ctr_addr,
    input  logic        ctr_dec,
    output logic        ctr_ack,
    output logic        ctr_ovf,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_ebank,
    input  logic [4:0]  cpu_fbank,
    input  logic        cpu_sbank,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_wprot,
    input  logic        dnl_req,
    input  logic [2:0]  dnl_ebank,
    input  logic [11:0] dnl_addr,
    output logic        dnl_ack,
    output logic [15:0] dnl_rdata,
    output logic [2:0]  mem_ebank,
    output logic [4:0]  mem_fbank,
    output logic        mem_sbank,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CPU    = 3'd1;
    localparam logic [2:0] S_DNL    = 3'd2;
    localparam logic [2:0] S_CTR_RD = 3'd3;
    localparam logic [2:0] S_CTR_WR = 3'd4;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_CTR  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_DNL  = 2'd3;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [2:0]    state;
    logic [1:0]    grant;
    logic [SW-1:0] starve_cnt;
    logic          dnl_forced;

    logic [2:0]  cap_ebank;
    logic [4:0]  cap_fbank;
    logic        cap_sbank;
    logic [11:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        cap_we;
    logic        cap_dec;
    logic [15:0] ctr_word;

    logic        cpu_prot;
    logic        ctr_prot;
    logic        ctr_wrap;
    logic [15:0] ctr_result;

    assign dnl_forced = (starve_cnt >= LIMIT);
    assign cpu_prot   = cap_we && ((cap_addr <= 12'h010) || (cap_addr >= 12'h400));
    assign ctr_prot   = (cap_addr[9:0] <= 10'h010);

    always_comb begin
        ctr_wrap   = cap_dec ? (ctr_word == 16'h0000) : (ctr_word == 16'h7FFF);
        ctr_result = 16'h0000;
        if (cap_dec) ctr_result = ctr_wrap ? 16'h7FFF : 16'(ctr_word - 16'd1);
        else         ctr_result = ctr_wrap ? 16'h0000 : 16'(ctr_word + 16'd1);
    end

    // A CPU request still held through its own ack is not regranted, but it
    // keeps DNL out, so only the starvation limit lets DNL past a busy CPU.
    always_comb begin
        grant = G_NONE;
        if (state == S_IDLE) begin
            if (ctr_req && !ctr_ack)                      grant = G_CTR;
            else if (dnl_forced && dnl_req && !dnl_ack)   grant = G_DNL;
            else if (cpu_req)                             grant = cpu_ack ? G_NONE : G_CPU;
            else if (dnl_req && !dnl_ack)                 grant = G_DNL;
        end
    end

    always_comb begin
        mem_ebank = 3'd0;
        mem_fbank = 5'd0;
        mem_sbank = 1'b0;
        mem_addr  = 12'd0;
        mem_wdata = 16'd0;
        mem_we    = 1'b0;
        case (state)
            S_CPU: begin
                mem_ebank = cap_ebank;
                mem_fbank = cap_fbank;
                mem_sbank = cap_sbank;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                mem_we    = cap_we && !cpu_prot;
            end
            S_DNL: begin
                mem_ebank = cap_ebank;
                mem_addr  = cap_addr;
            end
            S_CTR_RD: mem_addr = cap_addr;
            S_CTR_WR: begin
                mem_addr  = cap_addr;
                mem_wdata = ctr_result;
                mem_we    = !ctr_prot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            ctr_ack    <= 1'b0;
            ctr_ovf    <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_wprot  <= 1'b0;
            cpu_rdata  <= 16'd0;
            dnl_ack    <= 1'b0;
            dnl_rdata  <= 16'd0;
            cap_ebank  <= 3'd0;
            cap_fbank  <= 5'd0;
            cap_sbank  <= 1'b0;
            cap_addr   <= 12'd0;
            cap_wdata  <= 16'd0;
            cap_we     <= 1'b0;
            cap_dec    <= 1'b0;
            ctr_word   <= 16'd0;
        end else begin
            ctr_ack   <= 1'b0;
            ctr_ovf   <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_wprot <= 1'b0;
            dnl_ack   <= 1'b0;
            case (state)
                S_IDLE: begin
                    case (grant)
                        G_CTR: begin
                            state     <= S_CTR_RD;
                            cap_ebank <= 3'd0;
                            cap_fbank <= 5'd0;
                            cap_sbank <= 1'b0;
                            cap_addr  <= {2'b00, ctr_addr};
                            cap_we    <= 1'b0;
                            cap_dec   <= ctr_dec;
                        end
                        G_CPU: begin
                            state     <= S_CPU;
                            cap_ebank <= cpu_ebank;
                            cap_fbank <= cpu_fbank;
                            cap_sbank <= cpu_sbank;
                            cap_addr  <= cpu_addr;
                            cap_wdata <= cpu_wdata;
                            cap_we    <= cpu_we;
                            if (dnl_req && !dnl_forced) starve_cnt <= starve_cnt + SW'(1);
                        end
                        G_DNL: begin
                            state      <= S_DNL;
                            cap_ebank  <= dnl_ebank;
                            cap_fbank  <= 5'd0;
                            cap_sbank  <= 1'b0;
                            cap_addr   <= dnl_addr;
                            cap_we     <= 1'b0;
                            starve_cnt <= '0;
                        end
                        default: ;
                    endcase
                end
                S_CPU: begin
                    state     <= S_IDLE;
                    cpu_ack   <= 1'b1;
                    cpu_wprot <= cpu_prot;
                    if (!cap_we) cpu_rdata <= mem_rdata;
                end
                S_DNL: begin
                    state     <= S_IDLE;
                    dnl_ack   <= 1'b1;
                    dnl_rdata <= mem_rdata;
                end
                S_CTR_RD: begin
                    state    <= S_CTR_WR;
                    ctr_word <= mem_rdata;
                end
                S_CTR_WR: begin
                    state   <= S_IDLE;
                    ctr_ack <= 1'b1;
                    ctr_ovf <= ctr_wrap && !ctr_prot;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_agc_mem_scheduler.sv
// Bench for agc_mem_scheduler: models the memory, keeps a reference image of
// what the memory should hold, and checks directed and random transactions.
module tb_agc_mem_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctr_req = 1'b0, ctr_dec = 1'b0;
    logic [9:0]  ctr_addr = '0;
    logic        ctr_ack, ctr_ovf;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sbank = 1'b0;
    logic [2:0]  cpu_ebank = '0;
    logic [4:0]  cpu_fbank = '0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_wprot;
    logic [15:0] cpu_rdata;
    logic        dnl_req = 1'b0;
    logic [2:0]  dnl_ebank = '0;
    logic [11:0] dnl_addr = '0;
    logic        dnl_ack;
    logic [15:0] dnl_rdata;
    logic [2:0]  mem_ebank;
    logic [4:0]  mem_fbank;
    logic        mem_sbank;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:32767] = '{default: 16'h0000};
    logic [15:0] ref_mem [int];
    logic        poke_en = 1'b0;
    logic [14:0] poke_k = '0;
    logic [15:0] poke_v = '0;
    int n_pass = 0;
    int n_total = 0;

    agc_mem_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctr_req(ctr_req), .ctr_addr(ctr_addr), .ctr_dec(ctr_dec), .ctr_ack(ctr_ack), .ctr_ovf(ctr_ovf),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ebank(cpu_ebank), .cpu_fbank(cpu_fbank),
        .cpu_sbank(cpu_sbank), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .cpu_wprot(cpu_wprot),
        .dnl_req(dnl_req), .dnl_ebank(dnl_ebank), .dnl_addr(dnl_addr), .dnl_ack(dnl_ack), .dnl_rdata(dnl_rdata),
        .mem_ebank(mem_ebank), .mem_fbank(mem_fbank), .mem_sbank(mem_sbank), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    wire [14:0] mem_key = {mem_sbank, mem_fbank[0], mem_ebank[0], mem_addr};
    assign mem_rdata = mem[mem_key];
    always @(posedge clk) begin
        if (mem_we)       mem[mem_key] <= mem_wdata;
        else if (poke_en) mem[poke_k]  <= poke_v;
    end

    wire outs_any = |{ctr_ack, ctr_ovf, cpu_ack, cpu_rdata, cpu_wprot, dnl_ack, dnl_rdata,
                      mem_ebank, mem_fbank, mem_sbank, mem_addr, mem_wdata, mem_we};

    function automatic int key(input logic [2:0] eb, input logic [4:0] fb, input logic sb, input logic [11:0] a);
        return int'({sb, fb[0], eb[0], a});
    endfunction

    function automatic logic [15:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic poke(input int k, input logic [15:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_k = k[14:0]; poke_v = v;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[k] = v;
    endtask

    task automatic cpu_txn(input logic we, input logic [2:0] eb, input logic [4:0] fb, input logic sb,
                           input logic [11:0] a, input logic [15:0] d);
        int k, lat, wes;
        logic prot;
        logic [15:0] exp_rd;
        k = key(eb, fb, sb, a);
        prot = we && (a <= 12'h010 || a >= 12'h400);
        exp_rd = ref_rd(k);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_ebank = eb; cpu_fbank = fb; cpu_sbank = sb;
        cpu_addr = a; cpu_wdata = d;
        lat = 0; wes = 0;
        while (!cpu_ack && lat < 20) begin
            @(negedge clk); lat++;
            if (mem_we) wes++;
        end
        chk("cpu_latency", lat, 2);
        chk("cpu_we_cycles", wes, (we && !prot) ? 1 : 0);
        chk("cpu_wprot", cpu_wprot, prot);
        if (!we) chk("cpu_rdata", cpu_rdata, exp_rd);
        cpu_req = 1'b0;
        if (we && !prot) ref_mem[k] = d;
        chk("cpu_mem", mem[k], ref_rd(k));
    endtask

    task automatic dnl_txn(input logic [2:0] eb, input logic [11:0] a);
        int k, lat, wes;
        k = key(eb, 5'd0, 1'b0, a);
        @(negedge clk);
        dnl_req = 1'b1; dnl_ebank = eb; dnl_addr = a;
        lat = 0; wes = 0;
        while (!dnl_ack && lat < 20) begin
            @(negedge clk); lat++;
            if (mem_we) wes++;
        end
        chk("dnl_latency", lat, 3'd2);
        chk("dnl_we_cycles", wes, 0);
        chk("dnl_rdata", dnl_rdata, ref_rd(k));
        dnl_req = 1'b0;
    endtask

    task automatic ctr_txn(input logic [9:0] a, input logic dec);
        int k, lat, wes;
        logic [15:0] w, r;
        logic prot, ovf;
        k = key(3'd0, 5'd0, 1'b0, {2'b00, a});
        w = ref_rd(k);
        prot = (a <= 10'h010);
        ovf = !prot && (dec ? (w == 16'h0000) : (w == 16'h7FFF));
        if (dec) r = (w == 16'h0000) ? 16'h7FFF : w - 16'd1;
        else     r = (w == 16'h7FFF) ? 16'h0000 : w + 16'd1;
        @(negedge clk);
        ctr_req = 1'b1; ctr_addr = a; ctr_dec = dec;
        lat = 0; wes = 0;
        while (!ctr_ack && lat < 20) begin
            @(negedge clk); lat++;
            if (mem_we) wes++;
        end
        chk("ctr_latency", lat, 3);
        chk("ctr_ovf", ctr_ovf, ovf);
        chk("ctr_we_cycles", wes, prot ? 0 : 1);
        ctr_req = 1'b0;
        if (!prot) ref_mem[k] = r;
        chk("ctr_mem", mem[k], ref_rd(k));
    endtask

    initial begin
        logic [11:0] addr_tab [10];
        logic [15:0] ctr_vals [4];
        int t_ctr, t_cpu, t_dnl, code, nev, k;
        addr_tab = '{12'h000, 12'h010, 12'h011, 12'h020, 12'h021, 12'h3FF, 12'h400, 12'h7FF, 12'hFFF, 12'h155};
        ctr_vals = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};

        #1;
        chk("reset_outs_zero", outs_any, 0);
        repeat (2) @(negedge clk);
        chk("reset_outs_zero_clk", outs_any, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs_zero", outs_any, 0);

        cpu_txn(1'b1, 3'd2, 5'd0, 1'b0, 12'h300, 16'h1234);
        cpu_txn(1'b0, 3'd2, 5'd0, 1'b0, 12'h300, 16'h0000);
        chk("readback_1234", cpu_rdata, 16'h1234);

        cpu_txn(1'b1, 3'd0, 5'd0, 1'b0, 12'h005, 16'hBEEF);
        cpu_txn(1'b1, 3'd0, 5'd0, 1'b0, 12'h800, 16'hBEEF);
        chk("prot_low_unchanged", mem[key(3'd0, 5'd0, 1'b0, 12'h005)], 16'h0000);
        chk("prot_high_unchanged", mem[key(3'd0, 5'd0, 1'b0, 12'h800)], 16'h0000);

        cpu_txn(1'b1, 3'd0, 5'd0, 1'b0, 12'h020, 16'h7FFF);
        ctr_txn(10'h020, 1'b0);
        chk("pinc_wrap_value", mem[key(3'd0, 5'd0, 1'b0, 12'h020)], 16'h0000);
        cpu_txn(1'b1, 3'd0, 5'd0, 1'b0, 12'h021, 16'h0005);
        ctr_txn(10'h021, 1'b1);
        chk("minc_value", mem[key(3'd0, 5'd0, 1'b0, 12'h021)], 16'h0004);
        ctr_txn(10'h010, 1'b0);

        // All three requesters in the same cycle.
        @(negedge clk);
        ctr_req = 1'b1; ctr_addr = 10'h030; ctr_dec = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ebank = 3'd2; cpu_fbank = 5'd0; cpu_sbank = 1'b0; cpu_addr = 12'h300;
        dnl_req = 1'b1; dnl_ebank = 3'd2; dnl_addr = 12'h300;
        t_ctr = 0; t_cpu = 0; t_dnl = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ctr_ack && t_ctr == 0) begin t_ctr = c; ctr_req = 1'b0; end
            if (cpu_ack && t_cpu == 0) begin t_cpu = c; cpu_req = 1'b0; end
            if (dnl_ack && t_dnl == 0) begin t_dnl = c; dnl_req = 1'b0; end
        end
        chk("tri_ctr_ack_cycle", t_ctr, 3);
        chk("tri_cpu_ack_cycle", t_cpu, 5);
        chk("tri_dnl_ack_cycle", t_dnl, 7);
        chk("tri_dnl_rdata", dnl_rdata, 16'h1234);
        k = key(3'd0, 5'd0, 1'b0, 12'h030);
        ref_mem[k] = ref_rd(k) + 16'd1;
        chk("tri_ctr_mem", mem[k], ref_rd(k));

        // CPU held continuously with DNL waiting.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        dnl_req = 1'b1;
        code = 0; nev = 0;
        for (int c = 0; c < 80 && nev < 6; c++) begin
            @(negedge clk);
            if (cpu_ack) begin code = code * 10 + 1; nev++; end
            if (dnl_ack) begin code = code * 10 + 2; nev++; dnl_req = 1'b0; end
            if (nev >= 6) cpu_req = 1'b0;
        end
        cpu_req = 1'b0; dnl_req = 1'b0;
        chk("starve_order", code, 111121);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            logic [11:0] a;
            logic [2:0] eb;
            logic [4:0] fb;
            logic sb;
            a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 9)];
            eb = 3'($urandom_range(0, 1));
            fb = 5'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: cpu_txn(1'b1, eb, fb, sb, a, 16'($urandom));
                1: cpu_txn(1'b0, eb, fb, sb, a, 16'h0000);
                2: dnl_txn(eb, a);
                default: begin
                    if ($urandom_range(0, 2) == 0)
                        poke(key(3'd0, 5'd0, 1'b0, {2'b00, a[9:0]}), ctr_vals[$urandom_range(0, 3)]);
                    ctr_txn(a[9:0], 1'($urandom_range(0, 1)));
                end
            endcase
        end

        // Reset asserted while the counter write is on the bus.
        k = key(3'd0, 5'd0, 1'b0, 12'h040);
        poke(k, 16'h0123);
        @(negedge clk);
        ctr_req = 1'b1; ctr_addr = 10'h040; ctr_dec = 1'b0;
        repeat (2) @(negedge clk);
        chk("ctrwr_we_before_reset", mem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_we_drop", mem_we, 0);
        chk("reset_outs_zero_ctrwr", outs_any, 0);
        ctr_req = 1'b0;
        t_ctr = 0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_low_outs_zero", outs_any, 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ctr_ack) t_ctr++;
        end
        chk("reset_no_ctr_ack", t_ctr, 0);
        chk("reset_no_write", mem[k], 16'h0123);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/agc_mem_scheduler.md
# agc_mem_scheduler

Arbitrates the single-port AGC-style memory (eBank/fBank/superBank plus 12-bit address, 16-bit data, combinational read, posedge write) between three requesters. The requesters are the counter-increment unit (CTR), the CPU, and the telemetry downlink reader (DNL). The block sits directly in front of the memory and drives its bank, address, data and write-enable inputs. It performs CTR read-modify-write sequences autonomously and blocks writes that the memory would discard or that target fixed storage.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive CPU grants allowed while DNL waits before DNL is forced ahead of CPU.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctr_req`  in  1  counter increment request; held until `ctr_ack`.
- `ctr_addr`  in  10  unswitched-erasable counter address.
- `ctr_dec`  in  1  0 = PINC (+1), 1 = MINC (−1).
- `ctr_ack`  out  1  one-cycle completion pulse.
- `ctr_ovf`  out  1  valid with `ctr_ack`; counter wrapped.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write.
- `cpu_ebank`  in  3  E bank for the CPU access.
- `cpu_fbank`  in  5  F bank for the CPU access.
- `cpu_sbank`  in  1  superbank bit for the CPU access.
- `cpu_addr`  in  12  CPU address.
- `cpu_wdata`  in  16  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  16  read data; valid with `cpu_ack`, held until the next CPU access.
- `cpu_wprot`  out  1  valid with `cpu_ack`; the write was suppressed.
- `dnl_req`  in  1  downlink read request; held until `dnl_ack`.
- `dnl_ebank`  in  3  E bank for the downlink read.
- `dnl_addr`  in  12  downlink read address.
- `dnl_ack`  out  1  one-cycle completion pulse.
- `dnl_rdata`  out  16  downlink read data; same validity rules as `cpu_rdata`.
- `mem_ebank`  out  3  drives memory `eBank`.
- `mem_fbank`  out  5  drives memory `fBank`.
- `mem_sbank`  out  1  drives memory `superBank`.
- `mem_addr`  out  12  drives memory `memAddress`.
- `mem_wdata`  out  16  drives memory `dataIn`.
- `mem_we`  out  1  drives memory `writeEnable`.
- `mem_rdata`  in  16  memory `result`; combinational from the current address.

## Operation
- States: IDLE, CPU_ACC, DNL_ACC, CTR_RD, CTR_WR.
  - All access states return to IDLE except CTR_RD, which goes to CTR_WR.
- `mem_*` outputs are decoded from the registered state plus captured request fields. In IDLE they are all zero.
- Arbitration happens in IDLE only. Priority: CTR > DNL-forced > CPU > DNL.
  - A requester whose ack is asserted in the current cycle is ignored in that cycle's arbitration.
- Starvation counter:
  - Incremented on each CPU grant made while `dnl_req` is high.
  - Reaching `STARVE_LIMIT` sets DNL-forced.
  - Cleared on any DNL grant.
  - Saturates at the limit.
- CPU_ACC:
  - Drives the CPU bank and address fields.
  - On a read, captures `mem_rdata` into `cpu_rdata`.
  - On a write, `mem_we` = 1 unless the write is protected.
  - Protected writes: `cpu_addr` ≤ 12'h010 (register mirror) or `cpu_addr` ≥ 12'h400 (fixed memory). A protected write drives `mem_we` = 0 and sets `cpu_wprot`.
- DNL_ACC:
  - Drives `dnl_ebank`, `fbank` = 0, `sbank` = 0, `dnl_addr`.
  - Captures `mem_rdata` into `dnl_rdata`. Never writes.
- CTR_RD:
  - Drives banks = 0 and address = {2'b00, `ctr_addr`}.
  - Captures the word W.
- CTR_WR: writes the result R to the same address.
  - PINC: if W = 16'h7FFF then R = 16'h0000 and ovf = 1; otherwise R = W + 1.
  - MINC: if W = 16'h0000 then R = 16'h7FFF and ovf = 1; otherwise R = W − 1.
  - Other W values: 16-bit modular arithmetic, ovf = 0.
  - A CTR address ≤ 10'h010 completes with `mem_we` = 0 and ovf = 0.

## Timing
- Reset (asynchronous) forces:
  - state = IDLE and the starvation counter = 0;
  - all acks, `ctr_ovf` and `cpu_wprot` = 0;
  - `cpu_rdata` and `dnl_rdata` = 0;
  - all `mem_*` outputs = 0.
- Reset in CTR_WR suppresses the write: `mem_we` drops immediately. The request is not acked.
- Request sampled in IDLE at edge N:
  - the access cycle is N→N+1;
  - the ack pulses in cycle N+1→N+2, with data/flags valid.
- CPU and DNL latency is 2 cycles. CTR latency is 3 cycles.
- Maximum rate: one CPU/DNL access per 2 cycles; one CTR per 3 cycles.
- `ctr_req` arriving during a CPU_ACC is served in the next IDLE, ahead of a pending CPU request.
- Requests dropped before grant are discarded without ack. Request fields must be stable from `req` through the access cycle.

## Test plan
- After reset:
  - CPU writes 16'h1234 to E bank 2, address 12'h300 → `mem_we` is high for exactly 1 cycle and `cpu_ack` comes 2 cycles after the request.
  - A CPU read of the same location returns `cpu_rdata` = 16'h1234.
- CPU writes to 12'h005 and to 12'h800 → `mem_we` never asserts, `cpu_ack` and `cpu_wprot` = 1, memory unchanged.
- PINC on a counter holding 16'h7FFF → stored 16'h0000 with `ctr_ovf` = 1. MINC on 16'h0005 → 16'h0004 with `ctr_ovf` = 0. Each acks 3 cycles after the request.
- `ctr_req`, `cpu_req` and `dnl_req` all raised in the same cycle → grant order CTR, CPU, DNL:
  - acks at cycles +3, +5, +7.
- `cpu_req` held continuously with `dnl_req` pending and `STARVE_LIMIT` = 4 → exactly 4 CPU acks, then `dnl_ack`, then CPU service resumes.
- `rst_n` pulsed low during CTR_WR → no write occurs, `ctr_ack` stays 0, and all outputs are 0 while reset is low.
